// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning matrix keypad controller.
//
// One active-low column is driven at a time. The active-low row lines are
// synchronized and sampled once per column dwell. A single-row sample must
// repeat DEBOUNCE times before the key is accepted. An accepted key is
// reported by a one-cycle key_valid pulse. key_held stays high until an
// all-idle sample is seen.
//
// Optional feature: define KEYPAD_TYPEMATIC_EN to enable auto-repeat while a
// key is held. The first repeat comes REPEAT_DLY samples after the accept,
// and later repeats come every REPEAT_PER samples. Without the macro, exactly
// one pulse is produced per press and the repeat parameters are ignored.

module keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int REPEAT_DLY = 64,
    parameter int REPEAT_PER = 16,
    localparam int KW        = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_held,
    output logic            multi_key
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [ROWS-1:0] row_meta;
    logic [ROWS-1:0] row_sync;
    logic [DW-1:0]   div_cnt;
    logic            sample_tick;
    logic [CW-1:0]   col_idx;
    logic [CW-1:0]   col_next;
    logic [1:0]      state;
    logic [3:0]      match_cnt;
    logic [3:0]      match_next;
    logic [RW-1:0]   cap_row;
    logic [3:0]      low_cnt;
    logic [RW-1:0]   low_idx;
    logic            is_idle;
    logic            is_single;
    logic            is_multi;
    logic [KW-1:0]   new_code;

`ifdef KEYPAD_TYPEMATIC_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPW     = $clog2(REP_MAX + 1);

    logic [RPW-1:0] rep_cnt;
    logic [RPW-1:0] rep_next;
    logic           rep_first;
    logic           rep_hit;
`endif

    // Two-flop synchronizer on the asynchronous row lines; idle is all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Free-running dwell counter; its terminal count marks the sampling point
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (sample_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign sample_tick = (div_cnt == DW'(SCAN_DIV - 1));

    // Count low rows in the synchronized sample and remember which row was low
    always_comb begin
        low_cnt = 4'd0;
        low_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (!row_sync[i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = RW'(i);
            end
        end
    end

    assign is_idle   = (low_cnt == 4'd0);
    assign is_single = (low_cnt == 4'd1);
    assign is_multi  = (low_cnt >= 4'd2);

    // Next column index with wrap from the last column back to zero
    always_comb begin
        if (col_idx == CW'(COLS - 1)) begin
            col_next = '0;
        end else begin
            col_next = col_idx + CW'(1);
        end
    end

    // Key code of the key at the current column and the low row
    always_comb begin
        new_code = KW'(int'(col_idx) * ROWS + int'(low_idx));
    end

    assign match_next = match_cnt + 4'd1;

    // Drive exactly one column low, selected by the column index
    always_comb begin
        col          = '1;
        col[col_idx] = 1'b0;
    end

`ifdef KEYPAD_TYPEMATIC_EN
    // Repeat timing: the first interval uses the initial delay, later ones the period
    always_comb begin
        rep_next = rep_cnt + RPW'(1);
        if (rep_first) begin
            rep_hit = (rep_next == RPW'(REPEAT_DLY));
        end else begin
            rep_hit = (rep_next == RPW'(REPEAT_PER));
        end
    end
`endif

    // Scan / debounce / held state machine with the key_valid, key_code and multi_key registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SCAN;
            col_idx   <= '0;
            match_cnt <= 4'd0;
            cap_row   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            multi_key <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            if (sample_tick) begin
                multi_key <= is_multi;
                case (state)
                    ST_SCAN: begin
                        if (is_single) begin
                            cap_row   <= low_idx;
                            match_cnt <= 4'd1;
                            if (DEBOUNCE == 1) begin
                                key_code  <= new_code;
                                key_valid <= 1'b1;
                                state     <= ST_HELD;
`ifdef KEYPAD_TYPEMATIC_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_next;
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (is_single && (low_idx == cap_row)) begin
                            match_cnt <= match_next;
                            if (match_next == 4'(DEBOUNCE)) begin
                                key_code  <= new_code;
                                key_valid <= 1'b1;
                                state     <= ST_HELD;
`ifdef KEYPAD_TYPEMATIC_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end
                        end else begin
                            state   <= ST_SCAN;
                            col_idx <= col_next;
                        end
                    end

                    ST_HELD: begin
                        if (is_idle) begin
                            state   <= ST_SCAN;
                            col_idx <= col_next;
                        end else begin
`ifdef KEYPAD_TYPEMATIC_EN
                            if (rep_hit) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= '0;
                                rep_first <= 1'b0;
                            end else begin
                                rep_cnt <= rep_next;
                            end
`endif
                        end
                    end

                    default: begin
                        state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign key_held = (state == ST_HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner.
// Instance dut_a: 4x4 keypad, SCAN_DIV=4, DEBOUNCE=3.
// Instance dut_b: 3x5 keypad, SCAN_DIV=4, DEBOUNCE=1; used for the full key sweep.
// A behavioural keypad drives the row lines low only while its column is driven.
// Expected key codes are queued when a press is applied. A monitor pops and
// compares an entry on every key_valid cycle.

module tb_keypad_scanner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc;

    logic [3:0] row_a, col_a, code_a;
    logic       valid_a, held_a, multi_a;
    logic [2:0] row_b;
    logic [4:0] col_b;
    logic [3:0] code_b;
    logic       valid_b, held_b, multi_b;

    logic       press_a = 1'b0;
    logic [1:0] pc_a = 2'd0;
    logic [3:0] mask_a = 4'hF;
    logic       press_b = 1'b0;
    logic [2:0] pc_b = 3'd0;
    logic [2:0] mask_b = 3'h7;

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];
    int         pulses_a, pulses_b, last_cyc_a;
    bit         multi_seen_a;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic [1:0] c;
        logic [3:0] mask;
        int         hold;
        int         pulses;
        logic [3:0] code;
        bit         multi;
    } vec_t;

    vec_t vecs[7];

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_DLY(4), .REPEAT_PER(2)
    ) dut_a (
        .clk(clk), .reset(reset), .row(row_a), .col(col_a), .key_code(code_a),
        .key_valid(valid_a), .key_held(held_a), .multi_key(multi_a)
    );

    keypad_scanner #(
        .ROWS(3), .COLS(5), .SCAN_DIV(4), .DEBOUNCE(1), .REPEAT_DLY(4), .REPEAT_PER(2)
    ) dut_b (
        .clk(clk), .reset(reset), .row(row_b), .col(col_b), .key_code(code_b),
        .key_valid(valid_b), .key_held(held_b), .multi_key(multi_b)
    );

    always #5 clk = ~clk;

    // Cycle count since the last reset release; sample edges fall on multiples of 4
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Behavioural keypads: the pressed key pulls its rows low only while its column is driven
    always_comb begin
        row_a = (press_a && (col_a[pc_a] == 1'b0)) ? mask_a : 4'hF;
        row_b = (press_b && (col_b[pc_b] == 1'b0)) ? mask_b : 3'h7;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitors: every key_valid cycle must match a queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_a) begin
                pulses_a++;
                last_cyc_a = cyc;
                checkOutput("pulse_expected_a", 32'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) checkOutput("key_code_a", code_a, exp_a.pop_front());
            end
            if (multi_a) multi_seen_a = 1'b1;
            if (valid_b) begin
                pulses_b++;
                checkOutput("pulse_expected_b", 32'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) checkOutput("key_code_b", code_b, exp_b.pop_front());
            end
        end
    end

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset   = 1'b1;
        press_a = 1'b0;
        press_b = 1'b0;
        repeat (2) @(negedge clk);
        reset        = 1'b0;
        pulses_a     = 0;
        pulses_b     = 0;
        multi_seen_a = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        doReset();
        if (v.pulses > 0) exp_a.push_back(v.code);
        pc_a    = v.c;
        mask_a  = v.mask;
        press_a = 1'b1;
        waitCyc(v.hold * 4);
        press_a = 1'b0;
        waitCyc((v.hold + 3) * 4);
    endtask

    initial begin
        int n_rep;
        int last_rep;

        //          c     mask     hold pulses code  multi
        vecs[0] = '{2'd2, 4'b1101, 8,   1,     4'd9,  1'b0};
        vecs[1] = '{2'd1, 4'b1110, 3,   0,     4'd0,  1'b0};
        vecs[2] = '{2'd3, 4'b0111, 8,   1,     4'd15, 1'b0};
        vecs[3] = '{2'd0, 4'b1011, 6,   1,     4'd2,  1'b0};
        vecs[4] = '{2'd0, 4'b1001, 12,  0,     4'd0,  1'b1};
        vecs[5] = '{2'd1, 4'b0111, 4,   1,     4'd7,  1'b0};
        vecs[6] = '{2'd1, 4'b0111, 3,   0,     4'd0,  1'b0};

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_pulses", i), pulses_a, vecs[i].pulses);
            checkOutput($sformatf("v%0d_key_code", i), code_a, vecs[i].code);
            checkOutput($sformatf("v%0d_key_held", i), held_a, 0);
            checkOutput($sformatf("v%0d_multi_seen", i), multi_seen_a, vecs[i].multi);
            checkOutput($sformatf("v%0d_queue_left", i), exp_a.size(), 0);
        end

        // Accept timing for c=2,r=1, then a reset while HELD clears every output
        doReset();
        exp_a.push_back(4'd9);
        pc_a = 2'd2; mask_a = 4'b1101; press_a = 1'b1;
        waitCyc(19);
        checkOutput("acc_valid_before", valid_a, 0);
        waitCyc(20);
        checkOutput("acc_valid_at", valid_a, 1);
        checkOutput("acc_code", code_a, 9);
        checkOutput("acc_held", held_a, 1);
        waitCyc(21);
        checkOutput("acc_valid_after", valid_a, 0);
        waitCyc(32);
        checkOutput("held_still", held_a, 1);
        checkOutput("held_col_frozen", col_a, 4'b1011);
        reset = 1'b1; press_a = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_col", col_a, 4'b1110);
        checkOutput("rst_code", code_a, 0);
        checkOutput("rst_valid", valid_a, 0);
        checkOutput("rst_held", held_a, 0);
        checkOutput("rst_multi", multi_a, 0);
        reset = 1'b0;
        waitCyc(3);
        checkOutput("rst_first_col_hold", col_a, 4'b1110);
        waitCyc(4);
        checkOutput("rst_first_rotate", col_a, 4'b1101);
        checkOutput("acc_pulse_count", pulses_a, 1);

        // Key released after two matching samples: back to SCAN and rotate
        doReset();
        pc_a = 2'd1; mask_a = 4'b1110; press_a = 1'b1;
        waitCyc(12);
        press_a = 1'b0;
        waitCyc(15);
        checkOutput("abort_col_frozen", col_a, 4'b1101);
        waitCyc(16);
        checkOutput("abort_col_next", col_a, 4'b1011);
        waitCyc(20);
        checkOutput("abort_col_rotate", col_a, 4'b0111);
        checkOutput("abort_pulses", pulses_a, 0);

        // Two rows low in column 0: multi_key for exactly that dwell
        doReset();
        pc_a = 2'd0; mask_a = 4'b1001; press_a = 1'b1;
        waitCyc(4);
        press_a = 1'b0;
        checkOutput("multi_set", multi_a, 1);
        checkOutput("multi_col_rotates", col_a, 4'b1101);
        waitCyc(7);
        checkOutput("multi_dwell", multi_a, 1);
        waitCyc(8);
        checkOutput("multi_clear", multi_a, 0);
        checkOutput("multi_pulses", pulses_a, 0);

        // Reset one cycle before the accept of c=3,r=3
        doReset();
        pc_a = 2'd3; mask_a = 4'b0111; press_a = 1'b1;
        waitCyc(22);
        reset = 1'b1; press_a = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("late_rst_col", col_a, 4'b1110);
        checkOutput("late_rst_code", code_a, 0);
        reset = 1'b0;
        waitCyc(40);
        checkOutput("late_rst_pulses", pulses_a, 0);
        checkOutput("late_rst_code_after", code_a, 0);

        // Long hold of c=0,r=0: pulse count depends on auto-repeat
`ifdef KEYPAD_TYPEMATIC_EN
        n_rep = 5; last_rep = 52;
`else
        n_rep = 1; last_rep = 12;
`endif
        doReset();
        for (int i = 0; i < n_rep; i++) exp_a.push_back(4'd0);
        pc_a = 2'd0; mask_a = 4'b1110; press_a = 1'b1;
        waitCyc(52);
        press_a = 1'b0;
        waitCyc(64);
        checkOutput("hold_pulse_count", pulses_a, n_rep);
        checkOutput("hold_last_pulse_cyc", last_cyc_a, last_rep);
        checkOutput("hold_queue_left", exp_a.size(), 0);
        checkOutput("hold_released", held_a, 0);

        // 3x5 instance: column wrap, then a sweep of every key
        doReset();
        waitCyc(16);
        checkOutput("b_col_last", col_b, 5'b01111);
        waitCyc(20);
        checkOutput("b_col_wrap", col_b, 5'b11110);
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 3; r++) begin
                doReset();
                exp_b.push_back(4'(c * 3 + r));
                pc_b    = 3'(c);
                mask_b  = ~(3'b001 << r);
                press_b = 1'b1;
                waitCyc((c + 2) * 4);
                press_b = 1'b0;
                waitCyc((c + 4) * 4);
                checkOutput($sformatf("sweep_c%0d_r%0d_pulses", c, r), pulses_b, 1);
                checkOutput($sformatf("sweep_c%0d_r%0d_code", c, r), code_b, c * 3 + r);
                checkOutput($sformatf("sweep_c%0d_r%0d_held", c, r), held_b, 0);
            end
        end
        checkOutput("sweep_queue_left", exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got cyc %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of row inputs, range 2..8.
REQ-002 Parameter COLS, default 4: number of column outputs, range 2..8.
REQ-003 Parameter SCAN_DIV, default 1000: clock cycles per column dwell, range 4 or more.
REQ-004 Parameter DEBOUNCE, default 4: consecutive matching samples required, range 1..15.
REQ-005 Parameter REPEAT_DLY, default 64: samples from first key_valid to first repeat; used only with KEYPAD_TYPEMATIC_EN.
REQ-006 Parameter REPEAT_PER, default 16: samples between repeats; used only with KEYPAD_TYPEMATIC_EN.
REQ-007 Derived KW = clog2(ROWS*COLS): key code width.
REQ-008 clk  input  1  single clock; all logic is on the rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 row  input  ROWS  active-low row sense lines, asynchronous to clk.
REQ-011 col  output  COLS  active-low column drive; exactly one bit is low at all times.
REQ-012 key_code  output  KW  code of the last accepted key.
REQ-013 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-014 key_held  output  1  high while an accepted key remains pressed.
REQ-015 multi_key  output  1  high while the current sample has more than one row low.

Function
REQ-016 row shall pass through a 2-flop synchronizer; the synchronizer reset value is all ones.
REQ-017 A dwell counter 0..SCAN_DIV-1 shall run continuously.
  - A sample is the synchronized row value taken when the counter equals SCAN_DIV-1.
REQ-018 Column index c: col bit c low, all other bits high.
  - In SCAN, c advances by one after each sample.
  - Wrap: c = COLS-1 advances to 0.
  - c is frozen in all other states.
REQ-019 A sample is "single" when exactly one bit is low, giving row index r.
  - "Idle": all bits high.
  - "Multi": two or more bits low; multi_key = 1 for that dwell, registered.
REQ-020 Key code = c*ROWS + r, e.g. ROWS=4: c=0,r=1 gives 1; c=3,r=3 gives 15.
REQ-021 FSM states are SCAN, DEBOUNCE and HELD; the reset state is SCAN.
REQ-022 SCAN behaviour:
  - Single sample: capture c and r, set match count to 1, go to DEBOUNCE (if DEBOUNCE=1, go directly to accept).
  - Idle or multi sample: stay in SCAN and rotate.
REQ-023 DEBOUNCE behaviour:
  - Sample equal to the captured pattern: increment count.
  - Count reaching DEBOUNCE: accept, i.e. key_code loads, key_valid pulses for exactly one cycle, state goes to HELD.
  - Any other sample (idle, multi, different row): return to SCAN with no pulse, rotating to c+1.
REQ-024 HELD behaviour:
  - key_held = 1.
  - An idle sample returns to SCAN, rotating to c+1.
  - A non-idle sample of any kind keeps HELD, with no new pulse and key_code unchanged.
REQ-025 Accept latency: key_valid rises one clock after the DEBOUNCE-th matching sample.
REQ-026 key_code shall hold its value after release until the next accept.

Reset
REQ-027 On a reset cycle the block shall load: state SCAN, c = 0 (col = ~1), counters 0, key_code 0, key_valid 0, key_held 0, multi_key 0, synchronizer all ones.
REQ-028 Reset mid-DEBOUNCE or mid-HELD shall abort without any key_valid pulse.
  - The first sample after reset release occurs SCAN_DIV cycles later.

Configuration
REQ-029 With macro KEYPAD_TYPEMATIC_EN defined, auto-repeat applies in HELD:
  - A sample counter starts at the accept.
  - After REPEAT_DLY samples still non-idle, key_valid pulses again with the same key_code.
  - Thereafter it pulses every REPEAT_PER samples until an idle sample.
REQ-030 Without KEYPAD_TYPEMATIC_EN, exactly one key_valid pulse is produced per press.
  - The repeat counter logic is absent, and REPEAT_DLY and REPEAT_PER are ignored.

Verification
REQ-031 ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=3; press c=2,r=1 (row=4'b1101 while col=4'b1011) -> one key_valid pulse, key_code=9, key_held=1 until release.
REQ-032 Same configuration; press c=1,r=0 for 2 samples then release -> no key_valid, state returns to SCAN, col rotates to 4'b0111.
REQ-033 row=4'b1001 during column 0 -> multi_key=1 for that dwell, no key_valid, scanning continues.
REQ-034 Reset asserted one cycle before the accept of key c=3,r=3 -> no pulse, col=4'b1110 and key_code=0 after reset.
REQ-035 KEYPAD_TYPEMATIC_EN, REPEAT_DLY=4, REPEAT_PER=2, key c=0,r=0 held for 10 samples after accept -> pulses at the accept and at +4, +6, +8 and +10 samples, all with key_code=0.
REQ-036 ROWS=3, COLS=5 (KW=4) full sweep of every key -> codes 0..14 in c*3+r order, col wraps 4 to 0.
